// File: rtl/sonata_pkg.sv
// Shared definitions for the UART receive monitor.
//   DefClkFreq / DefBaudRate : default system clock and serial bit rate
//   uart_rx_state_e          : receiver FSM state encoding
package sonata_pkg;

    localparam int unsigned DefClkFreq  = 30_000_000;
    localparam int unsigned DefBaudRate = 921_600;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO with registered storage.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i       : write wdata_i (accepted if not full, or full with a same-cycle pop)
//   pop_i        : consume head (ignored while empty)
//   rdata_o      : head entry, zero while empty
//   rvalid_o     : FIFO non-empty
//   full_o       : FIFO holds Depth entries
//   level_o      : occupancy 0..Depth
module uart_rx_fifo #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     rvalid_o,
    output logic                     full_o,
    output logic [$clog2(Depth):0]   level_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam logic [AW:0] FullLevel = (AW+1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full_o  = (count_q == FullLevel);
    assign do_pop  = pop_i && !empty;
    // When full, the slot being freed by a same-cycle pop is the one written.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rvalid_o = !empty;
    assign rdata_o  = empty ? '0 : mem_q[rptr_q];
    assign level_o  = count_q;

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receiver that decodes 8N1 frames from an asynchronous line and
// queues the bytes in a FIFO.
//   clk_i, rst_i : clock, synchronous active-high reset
//   rx_i         : asynchronous serial input, idle high
//   rdata_o      : head-of-FIFO byte
//   rvalid_o     : FIFO non-empty
//   rready_i     : consumer accepts rdata_o (pop when rvalid_o && rready_i)
//   frame_err_o  : one-cycle pulse on a bad stop bit
//   overflow_o   : sticky, a byte was dropped on a full FIFO
//   level_o      : FIFO occupancy
//
// state     | meaning
// ----------|----------------------------------------------------------
// IDLE      | line high, waiting for a falling edge
// START     | half a bit in, confirm the start bit is still low
// DATA      | sampling 8 data bits at mid-bit, LSB first
// STOP      | sampling the stop bit; high pushes, low flags a frame error
// WAIT_IDLE | after a frame error, wait for the line to return high
module uart_rx_monitor
    import sonata_pkg::*;
#(
    parameter int unsigned ClkFreq   = DefClkFreq,
    parameter int unsigned BaudRate  = DefBaudRate,
    parameter int unsigned FifoDepth = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        rx_i,
    output logic [7:0]                  rdata_o,
    output logic                        rvalid_o,
    input  logic                        rready_i,
    output logic                        frame_err_o,
    output logic                        overflow_o,
    output logic [$clog2(FifoDepth):0]  level_o
);

    localparam int unsigned BitCycles  = ClkFreq / BaudRate;
    localparam int unsigned HalfCycles = BitCycles / 2;
    localparam int unsigned CntW       = (BitCycles > 2) ? $clog2(BitCycles) : 1;
    localparam logic [CntW-1:0] BitLoad  = CntW'(BitCycles - 1);
    localparam logic [CntW-1:0] HalfLoad = CntW'((HalfCycles > 0) ? HalfCycles - 1 : 0);

    logic            rx_meta_q;
    logic            rx_s;
    uart_rx_state_e  state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            push;
    logic            ferr_d;
    logic            frame_err_q;
    logic            overflow_q;
    logic            fifo_full;
    logic            cnt_zero;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s      <= rx_meta_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= ferr_d;
        end
    end

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push    = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = HalfLoad;
                    state_d = START;
                end
            end
            START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rx_s) begin
                    cnt_d   = BitLoad;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = BitLoad;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    push    = rx_s;
                    ferr_d  = !rx_s;
                    state_d = rx_s ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO only accepts a push when the consumer pops in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
        end else if (push && fifo_full && !rready_i) begin
            overflow_q <= 1'b1;
        end
    end

    uart_rx_fifo #(
        .Depth (FifoDepth),
        .Width (8)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (push),
        .wdata_i  (shift_q),
        .pop_i    (rready_i),
        .rdata_o  (rdata_o),
        .rvalid_o (rvalid_o),
        .full_o   (fifo_full),
        .level_o  (level_o)
    );

    assign frame_err_o = frame_err_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
module tb_uart_rx_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rready = 1'b1;
    logic [7:0] rdata;
    logic       rvalid;
    logic       frame_err;
    logic       overflow;
    logic [4:0] level;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int start_cyc = 0;
    int first_pop_cyc = -1;
    int ferr_cnt = 0;
    logic [7:0] got_q[$];

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         hold_low;
        int         exp_rx;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[5];

    uart_rx_monitor #(
        .ClkFreq   (30_000_000),
        .BaudRate  (921_600),
        .FifoDepth (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_i        (rx),
        .rdata_o     (rdata),
        .rvalid_o    (rvalid),
        .rready_i    (rready),
        .frame_err_o (frame_err),
        .overflow_o  (overflow),
        .level_o     (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (rvalid && rready) begin
                got_q.push_back(rdata);
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
            end
            if (frame_err) ferr_cnt++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int hold_low);
        @(posedge clk);
        #1 rx = 1'b0;
        start_cyc = cyc;
        repeat (32) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (32) @(posedge clk);
        end
        #1 rx = stop_ok;
        repeat (32 + hold_low) @(posedge clk);
        #1 rx = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int q_at(input int k);
        if (k < got_q.size()) return int'(got_q[k]);
        return -1;
    endfunction

    initial begin
        vecs[0] = '{8'h3C, 1'b1, 0,  1, 0};
        vecs[1] = '{8'h00, 1'b1, 0,  1, 0};
        vecs[2] = '{8'hFF, 1'b1, 0,  1, 0};
        vecs[3] = '{8'h55, 1'b0, 64, 0, 1};
        vecs[4] = '{8'h12, 1'b1, 0,  1, 0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_rvalid", int'(rvalid), 0);
        check("reset_rdata", int'(rdata), 0);
        check("reset_ferr", int'(frame_err), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_level", int'(level), 0);
        rst = 1'b0;
        idle(4);

        // 0xA5 with latency bound
        got_q.delete();
        first_pop_cyc = -1;
        send_byte(8'hA5, 1'b1, 0);
        idle(40);
        check("a5_count", got_q.size(), 1);
        check("a5_data", q_at(0), 'hA5);
        check("a5_latency_ok",
              int'(first_pop_cyc - start_cyc >= 300 && first_pop_cyc - start_cyc <= 324), 1);

        // 8-cycle glitch
        got_q.delete();
        ferr_cnt = 0;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (8) @(posedge clk);
        #1 rx = 1'b1;
        idle(64);
        check("glitch_count", got_q.size(), 0);
        check("glitch_ferr", ferr_cnt, 0);
        check("glitch_level", int'(level), 0);

        // table of frames
        for (int v = 0; v < 5; v++) begin
            got_q.delete();
            ferr_cnt = 0;
            send_byte(vecs[v].data, vecs[v].stop_ok, vecs[v].hold_low);
            idle(40);
            check($sformatf("vec%0d_count", v), got_q.size(), vecs[v].exp_rx);
            if (vecs[v].exp_rx == 1)
                check($sformatf("vec%0d_data", v), q_at(0), int'(vecs[v].data));
            check($sformatf("vec%0d_ferr", v), ferr_cnt, vecs[v].exp_ferr);
            check($sformatf("vec%0d_level", v), int'(level), 0);
        end

        // overflow: 17 bytes with no consumer
        rready = 1'b0;
        for (int i = 0; i <= 16; i++) send_byte(8'(i), 1'b1, 0);
        idle(4);
        check("ovf_level", int'(level), 16);
        check("ovf_flag", int'(overflow), 1);
        check("ovf_rvalid", int'(rvalid), 1);
        check("ovf_head", int'(rdata), 0);
        got_q.delete();
        rready = 1'b1;
        idle(20);
        rready = 1'b0;
        check("ovf_drain_count", got_q.size(), 16);
        for (int k = 0; k < 16; k++) check($sformatf("ovf_drain%0d", k), q_at(k), k);
        check("ovf_drain_level", int'(level), 0);
        check("ovf_sticky", int'(overflow), 1);

        // full FIFO with pop coinciding with the 17th push
        do_reset();
        check("rst_clears_ovf", int'(overflow), 0);
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 1'b1, 0);
        idle(2);
        check("full_level", int'(level), 16);
        got_q.delete();
        fork
            send_byte(8'h30, 1'b1, 0);
            begin
                @(posedge clk);
                repeat (306) @(posedge clk);
                #1 rready = 1'b1;
                @(posedge clk);
                #1 rready = 1'b0;
            end
        join
        idle(2);
        check("simul_level", int'(level), 16);
        check("simul_ovf", int'(overflow), 0);
        check("simul_pop_count", got_q.size(), 1);
        check("simul_pop_data", q_at(0), 'h20);
        rready = 1'b1;
        idle(20);
        check("simul_drain_count", got_q.size(), 17);
        for (int k = 0; k < 17; k++) check($sformatf("simul_order%0d", k), q_at(k), 'h20 + k);

        // reset in the middle of a frame with bytes queued
        do_reset();
        rready = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(8'(8'h40 + i), 1'b1, 0);
        idle(2);
        check("pre_rst_level", int'(level), 3);
        ferr_cnt = 0;
        fork
            send_byte(8'hFF, 1'b1, 0);
            begin
                @(posedge clk);
                repeat (32 * 5 + 16) @(posedge clk);
                #1 rst = 1'b1;
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        idle(40);
        check("midrst_rvalid", int'(rvalid), 0);
        check("midrst_level", int'(level), 0);
        check("midrst_ferr", ferr_cnt, 0);
        got_q.delete();
        rready = 1'b1;
        send_byte(8'h81, 1'b1, 0);
        idle(40);
        check("after_rst_count", got_q.size(), 1);
        check("after_rst_data", q_at(0), 'h81);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
